// File: rtl/branch_predictor_if.sv
// Fetch/execute-side bundle for branch_predictor: IF lookup, EX resolved-branch update, mispredict result.
// The master modport is the core; the slave modport is the predictor.
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic            lookup_pc_unused_guard;
  logic [XLEN-1:0] lookup_pc;
  logic            pred_taken;
  logic [XLEN-1:0] pred_target;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic            upd_is_cond;
  logic            upd_taken;
  logic [XLEN-1:0] upd_target;
  logic            upd_pred_taken;
  logic [XLEN-1:0] upd_pred_target;
  logic            clear;
  logic            mispredict;

  modport master (
    output lookup_pc, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, clear,
    input  pred_taken, pred_target, mispredict
  );

  modport slave (
    input  lookup_pc, upd_valid, upd_pc, upd_is_cond, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target, clear,
    output pred_taken, pred_target, mispredict
  );
endinterface

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters, 0-cycle lookup and EX-stage update.
// Define GSHARE_EN to XOR a non-speculative global history into the counter index.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64,
  parameter int CNT_W   = 2,
  parameter int HIST_W  = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  branch_predictor_if.slave    bus
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - 2 - IDX_W;

  localparam logic [CNT_W-1:0] CTR_RST = CNT_W'((1 << (CNT_W - 1)) - 1);
  localparam logic [CNT_W-1:0] CTR_WT  = CNT_W'(1 << (CNT_W - 1));
  localparam logic [CNT_W-1:0] CTR_MAX = '1;

  logic [ENTRIES-1:0] r_valid;
  logic [ENTRIES-1:0] r_isJal;
  logic [TAG_W-1:0]   r_tag    [ENTRIES];
  logic [XLEN-1:0]    r_target [ENTRIES];
  logic [CNT_W-1:0]   r_ctr    [ENTRIES];

  logic [IDX_W-1:0] w_lkIdx;
  logic [TAG_W-1:0] w_lkTag;
  logic [IDX_W-1:0] w_lkCidx;
  logic             w_lkHit;
  logic [IDX_W-1:0] w_updIdx;
  logic [TAG_W-1:0] w_updTag;
  logic [IDX_W-1:0] w_updCidx;
  logic             w_updHit;
  logic             w_unused;

  assign w_unused = ^{bus.lookup_pc[1:0], bus.upd_pc[1:0], bus.upd_pred_taken};

  assign w_lkIdx  = bus.lookup_pc[IDX_W+1:2];
  assign w_lkTag  = bus.lookup_pc[XLEN-1:IDX_W+2];
  assign w_updIdx = bus.upd_pc[IDX_W+1:2];
  assign w_updTag = bus.upd_pc[XLEN-1:IDX_W+2];

`ifdef GSHARE_EN
  logic [HIST_W-1:0] r_ghr;

  // History only advances on committed conditional branches, so it never needs repair.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ghr <= '0;
    end else if (bus.upd_valid && bus.upd_is_cond && !bus.clear) begin
      r_ghr <= (r_ghr << 1) | HIST_W'(bus.upd_taken);
    end
  end

  assign w_lkCidx  = w_lkIdx ^ IDX_W'(r_ghr);
  assign w_updCidx = w_updIdx ^ IDX_W'(r_ghr);
`else
  assign w_lkCidx  = w_lkIdx;
  assign w_updCidx = w_updIdx;
`endif

  assign w_lkHit  = r_valid[w_lkIdx] && (r_tag[w_lkIdx] == w_lkTag);
  assign w_updHit = r_valid[w_updIdx] && (r_tag[w_updIdx] == w_updTag);

  assign bus.pred_taken  = w_lkHit && (r_isJal[w_lkIdx] || r_ctr[w_lkCidx][CNT_W-1]);
  assign bus.pred_target = bus.pred_taken ? r_target[w_lkIdx] : bus.lookup_pc + XLEN'(4);

  assign bus.mispredict = bus.upd_valid &&
                          ((bus.upd_taken != bus.upd_pred_taken) ||
                           (bus.upd_taken && (bus.upd_target != bus.upd_pred_target)));

  // Clear has priority over an update in the same cycle; a JAL entry never moves its counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_isJal <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= CTR_RST;
      end
    end else if (bus.clear) begin
      r_valid <= '0;
    end else if (bus.upd_valid) begin
      if (w_updHit) begin
        if (bus.upd_is_cond && !r_isJal[w_updIdx]) begin
          if (bus.upd_taken && (r_ctr[w_updCidx] != CTR_MAX)) begin
            r_ctr[w_updCidx] <= r_ctr[w_updCidx] + CNT_W'(1);
          end else if (!bus.upd_taken && (r_ctr[w_updCidx] != '0)) begin
            r_ctr[w_updCidx] <= r_ctr[w_updCidx] - CNT_W'(1);
          end
        end
        if (bus.upd_taken) begin
          r_target[w_updIdx] <= bus.upd_target;
        end
        r_isJal[w_updIdx] <= !bus.upd_is_cond;
      end else if (bus.upd_taken) begin
        r_valid[w_updIdx]  <= 1'b1;
        r_tag[w_updIdx]    <= w_updTag;
        r_target[w_updIdx] <= bus.upd_target;
        r_isJal[w_updIdx]  <= !bus.upd_is_cond;
        r_ctr[w_updCidx]   <= CTR_WT;
      end
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: vector table, hand-written corner sequences, and a
// randomized phase compared against an array-based reference model (also models GSHARE_EN history).
module tb_branch_predictor;

  localparam int XLEN   = 32;
  localparam int ENT    = 64;
  localparam int CNTW   = 2;
  localparam int HISTW  = 6;
  localparam int WT     = 1 << (CNTW - 1);
  localparam int CMAX   = (1 << CNTW) - 1;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  branch_predictor_if #(.XLEN(XLEN)) bus ();

  branch_predictor #(
    .XLEN(XLEN), .ENTRIES(ENT), .CNT_W(CNTW), .HIST_W(HISTW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arrays indexed by (pc/4) mod ENT, tag is pc/(4*ENT).
  bit          mValid [ENT];
  longint      mTagArr[ENT];
  logic [31:0] mTgt   [ENT];
  bit          mJal   [ENT];
  int          mCtr   [ENT];
  int          mGhr;

  function automatic int idxOf(logic [31:0] pc);
    return int'((pc / 4) % ENT);
  endfunction

  function automatic longint tagOf(logic [31:0] pc);
    return longint'(pc / (4 * ENT));
  endfunction

  function automatic int cidxOf(logic [31:0] pc);
`ifdef GSHARE_EN
    return idxOf(pc) ^ mGhr;
`else
    return idxOf(pc);
`endif
  endfunction

  task automatic modelReset();
    for (int i = 0; i < ENT; i++) begin
      mValid[i] = 0; mTagArr[i] = 0; mTgt[i] = 0; mJal[i] = 0; mCtr[i] = WT - 1;
    end
    mGhr = 0;
  endtask

  task automatic modelPredict(input logic [31:0] pc, output bit t, output logic [31:0] tgt);
    int i;
    bit hit;
    i   = idxOf(pc);
    hit = mValid[i] && (mTagArr[i] == tagOf(pc));
    t   = hit && (mJal[i] || (mCtr[cidxOf(pc)] >= WT));
    tgt = t ? mTgt[i] : pc + 32'd4;
  endtask

  task automatic modelUpdate(input bit v, input logic [31:0] pc, input bit isCond, input bit taken,
                             input logic [31:0] target, input bit clr);
    int i;
    int c;
    bit hit;
    if (clr) begin
      for (int k = 0; k < ENT; k++) mValid[k] = 0;
      return;
    end
    if (!v) return;
    i   = idxOf(pc);
    c   = cidxOf(pc);
    hit = mValid[i] && (mTagArr[i] == tagOf(pc));
    if (hit) begin
      if (isCond && !mJal[i]) begin
        if (taken) mCtr[c] = (mCtr[c] < CMAX) ? mCtr[c] + 1 : CMAX;
        else       mCtr[c] = (mCtr[c] > 0) ? mCtr[c] - 1 : 0;
      end
      if (taken) mTgt[i] = target;
      mJal[i] = !isCond;
    end else if (taken) begin
      mValid[i] = 1; mTagArr[i] = tagOf(pc); mTgt[i] = target; mJal[i] = !isCond; mCtr[c] = WT;
    end
    if (isCond) mGhr = (mGhr * 2 + int'(taken)) % (1 << HISTW);
  endtask

  task automatic applyStimulus(input logic [31:0] lookupPc, input bit v, input logic [31:0] pc,
                               input bit isCond, input bit taken, input logic [31:0] target,
                               input bit predTaken, input logic [31:0] predTarget, input bit clr);
    @(negedge clk);
    bus.lookup_pc       = lookupPc;
    bus.upd_valid       = v;
    bus.upd_pc          = pc;
    bus.upd_is_cond     = isCond;
    bus.upd_taken       = taken;
    bus.upd_target      = target;
    bus.upd_pred_taken  = predTaken;
    bus.upd_pred_target = predTarget;
    bus.clear           = clr;
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkPred(input string name, input bit expT, input logic [31:0] expTgt);
    checkOutput({name, ".taken"}, 32'(bus.pred_taken), 32'(expT));
    checkOutput({name, ".target"}, bus.pred_target, expTgt);
  endtask

  // Idle cycle helper: lookup only, no update.
  task automatic look(input logic [31:0] pc);
    applyStimulus(pc, 0, 32'h0, 1, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic upd(input logic [31:0] lookupPc, input logic [31:0] pc, input bit isCond,
                     input bit taken, input logic [31:0] target, input bit clr);
    applyStimulus(lookupPc, 1, pc, isCond, taken, target, 0, 32'h0, clr);
  endtask

  typedef struct {
    string       name;
    logic [31:0] lookupPc;
    bit          updValid;
    bit          updTaken;
    logic [31:0] updTarget;
    bit          updPredTaken;
    logic [31:0] updPredTarget;
    bit          expTaken;
    logic [31:0] expTarget;
    bit          expMisp;
  } vec_t;

  vec_t vecs[$];

  initial begin
    bit          mt;
    logic [31:0] mtgt;
    bit          uv, uc, ut, upt, clr;
    logic [31:0] lpc, upc, utg, uptg;

    checks = 0;
    errors = 0;
    reset  = 1'b1;
    bus.lookup_pc = 0; bus.upd_valid = 0; bus.upd_pc = 0; bus.upd_is_cond = 0;
    bus.upd_taken = 0; bus.upd_target = 0; bus.upd_pred_taken = 0; bus.upd_pred_target = 0;
    bus.clear = 0;
    #1;
    bus.lookup_pc = 32'h100;
    #1;
    checkPred("in_reset", 0, 32'h104);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Vector rows run with clear=1 so the table never changes predictor state.
    vecs.push_back('{"rst_0x100",   32'h100,      0, 0, 32'h0,  0, 32'h0,  0, 32'h104, 0});
    vecs.push_back('{"rst_wrap",    32'hFFFFFFFC, 0, 0, 32'h0,  0, 32'h0,  0, 32'h0,   0});
    vecs.push_back('{"rst_zero",    32'h0,        0, 0, 32'h0,  0, 32'h0,  0, 32'h4,   0});
    vecs.push_back('{"mp_tgt_diff", 32'h104,      1, 1, 32'h90, 1, 32'h80, 0, 32'h108, 1});
    vecs.push_back('{"mp_tgt_same", 32'h104,      1, 1, 32'h80, 1, 32'h80, 0, 32'h108, 0});
    vecs.push_back('{"mp_nt_nt",    32'h104,      1, 0, 32'h90, 0, 32'h80, 0, 32'h108, 0});
    vecs.push_back('{"mp_nt_t",     32'h104,      1, 0, 32'h80, 1, 32'h80, 0, 32'h108, 1});
    vecs.push_back('{"mp_t_nt",     32'h104,      1, 1, 32'h80, 0, 32'h80, 0, 32'h108, 1});
    vecs.push_back('{"mp_invalid",  32'h104,      0, 1, 32'h90, 0, 32'h80, 0, 32'h108, 0});
    vecs.push_back('{"clr_drop",    32'h500,      0, 0, 32'h0,  0, 32'h0,  0, 32'h504, 0});

    foreach (vecs[n]) begin
      applyStimulus(vecs[n].lookupPc, vecs[n].updValid, 32'h500, 1, vecs[n].updTaken,
                    vecs[n].updTarget, vecs[n].updPredTaken, vecs[n].updPredTarget, 1);
      checkPred(vecs[n].name, vecs[n].expTaken, vecs[n].expTarget);
      checkOutput({vecs[n].name, ".misp"}, 32'(bus.mispredict), 32'(vecs[n].expMisp));
    end

    // Allocation, tag alias, counter saturation walk.
    upd(32'h100, 32'h100, 1, 1, 32'h80, 0);
    look(32'h100); checkPred("alloc_hit", 1, 32'h80);
    look(32'h200); checkPred("alias_miss", 0, 32'h204);
    upd(32'h100, 32'h100, 1, 0, 32'h0, 0);
    look(32'h100); checkPred("ctr1", 0, 32'h104);
    upd(32'h100, 32'h100, 1, 0, 32'h0, 0);
    upd(32'h100, 32'h100, 1, 0, 32'h0, 0);
    upd(32'h100, 32'h100, 1, 1, 32'h80, 0);
    look(32'h100); checkPred("sat0_up1", 0, 32'h104);
    upd(32'h100, 32'h100, 1, 1, 32'h80, 0);
    look(32'h100); checkPred("ctr2", 1, 32'h80);

    // JAL overwrites the aliasing entry; a conditional hit on a JAL entry leaves its counter alone.
    upd(32'h200, 32'h200, 0, 1, 32'h40, 0);
    look(32'h200); checkPred("jal_hit", 1, 32'h40);
    look(32'h100); checkPred("jal_evict", 0, 32'h104);
    upd(32'h200, 32'h200, 1, 0, 32'h0, 0);
    look(32'h200); checkPred("jal_ctr_kept", 1, 32'h40);
    upd(32'h200, 32'h200, 1, 0, 32'h0, 0);
    look(32'h200); checkPred("cond_after_jal", 0, 32'h204);

    // Same-cycle update/lookup has no bypass; clear beats a simultaneous update.
    upd(32'h300, 32'h300, 1, 1, 32'h3A0, 0);
    checkPred("same_cycle", 0, 32'h304);
    look(32'h300); checkPred("next_cycle", 1, 32'h3A0);
    upd(32'h300, 32'h340, 1, 1, 32'h10, 1);
    checkPred("pre_clear", 1, 32'h3A0);
    look(32'h300); checkPred("cleared", 0, 32'h304);
    look(32'h340); checkPred("clr_upd_drop", 0, 32'h344);

    // Asynchronous reset between clock edges.
    upd(32'h400, 32'h400, 1, 1, 32'h44, 0);
    look(32'h400); checkPred("pre_reset", 1, 32'h44);
    #2 reset = 1'b1;
    #1 checkPred("async_reset", 0, 32'h404);
    @(negedge clk);
    reset = 1'b0;
    modelReset();

    // Randomized phase against the model.
    for (int n = 0; n < 400; n++) begin
      lpc  = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFC :
             32'h1000 + 4 * $urandom_range(0, 5) + 4 * ENT * $urandom_range(0, 1);
      upc  = 32'h1000 + 4 * $urandom_range(0, 5) + 4 * ENT * $urandom_range(0, 1);
      uv   = $urandom_range(0, 3) != 0;
      uc   = $urandom_range(0, 4) != 0;
      ut   = uc ? bit'($urandom_range(0, 1)) : 1'b1;
      utg  = 32'h40 * $urandom_range(1, 3);
      clr  = $urandom_range(0, 39) == 0;
      if ($urandom_range(0, 1) == 1) begin
        modelPredict(upc, upt, uptg);
      end else begin
        upt  = bit'($urandom_range(0, 1));
        uptg = 32'h40 * $urandom_range(1, 3);
      end
      applyStimulus(lpc, uv, upc, uc, ut, utg, upt, uptg, clr);
      modelPredict(lpc, mt, mtgt);
      checkPred("rand", mt, mtgt);
      checkOutput("rand.misp", 32'(bus.mispredict),
                  32'(uv && ((ut != upt) || (ut && (utg != uptg)))));
      modelUpdate(uv, upc, uc, ut, utg, clr);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
Parametrised BTB plus saturating-counter branch predictor for the pipelined RV32I core. IF stage gets a same-cycle prediction for the current PC. EX stage writes back resolved branch/JAL outcomes and gets a mispredict flag for redirect/flush. Replaces the core's stall-on-every-branch policy with predict-and-recover.

Parameters:
XLEN, 32, address/data width
ENTRIES, 64, BTB/counter entries; power of 2, >=2; IDX_W = log2(ENTRIES), TAG_W = XLEN-2-IDX_W
CNT_W, 2, saturating counter width, >=1
HIST_W, 6, global history length; must be <= IDX_W; used only with GSHARE_EN

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
lookup_pc  in  XLEN  IF-stage PC
pred_taken  out  1  predicted taken (combinational)
pred_target  out  XLEN  predicted next PC (combinational)
upd_valid  in  1  EX resolved a conditional branch or JAL this cycle
upd_pc  in  XLEN  PC of resolved instruction
upd_is_cond  in  1  1 = conditional branch, 0 = JAL
upd_taken  in  1  actual direction
upd_target  in  XLEN  actual target
upd_pred_taken  in  1  prediction carried down pipeline
upd_pred_target  in  XLEN  predicted target carried down pipeline
clear  in  1  synchronous invalidate of all BTB entries
mispredict  out  1  combinational mispredict flag for the update

Behaviour:
- Per entry: valid, tag[TAG_W], target[XLEN], is_jal, ctr[CNT_W].
- idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2]; pc[1:0] ignored.
- Reset (async): all valid=0, ctr = 2^(CNT_W-1)-1 (weakly not-taken), is_jal=0, ghr=0. Outputs then: pred_taken=0, pred_target=lookup_pc+4.
- Lookup (0-cycle, combinational): hit = valid[idx] && tag match.
  - pred_taken = hit && (is_jal[idx] || ctr[cidx] MSB).
  - pred_target = pred_taken ? target[idx] : lookup_pc+4. Arithmetic is modulo 2^XLEN, so 0xFFFFFFFC+4 = 0.
- mispredict = upd_valid && (upd_taken != upd_pred_taken || (upd_taken && upd_target != upd_pred_target)).
- Update (posedge clk, upd_valid=1, clear=0):
  - Hit, conditional: ctr saturating +1 if taken, -1 if not. Bounds are 0 and 2^CNT_W-1.
  - Hit, any type: if taken, target <= upd_target. is_jal <= !upd_is_cond.
  - Miss, taken: allocate (overwrite) the entry. valid=1, tag, target, is_jal = !upd_is_cond, ctr[cidx] = 2^(CNT_W-1) (weakly taken).
  - Miss, not taken: no state change.
  - JAL entries never modify ctr.
- Same-cycle lookup and update to same idx: lookup returns pre-update contents; no bypass. New state is visible next cycle.
- clear: all valid <= 0 next edge. Counters, targets and ghr are unchanged. If clear and upd_valid are both 1, clear wins and the update is dropped (mispredict still computed).
- Reset asserted mid-operation: state cleared immediately, independent of clk.
- Without GSHARE_EN: cidx = idx (counter shares BTB index).

Optional Feature:
GSHARE_EN
- Defined: adds HIST_W-bit register ghr.
  - On upd_valid && upd_is_cond && !clear: ghr <= {ghr[HIST_W-2:0], upd_taken}. History is non-speculative.
  - Counter index cidx = idx ^ zero-extended ghr; applies to lookup (with current ghr) and update (with ghr before shift). BTB valid/tag/target/is_jal stay indexed by idx.
  - Counters live in a separate ENTRIES-deep array.
- Undefined: no ghr, cidx = idx, no extra array. HIST_W is ignored.

Test Plan:
- Reset, lookup_pc=0x100 -> pred_taken=0, pred_target=0x104. lookup_pc=0xFFFFFFFC -> pred_target=0x00000000.
- Update cond taken pc=0x100 target=0x80. Next cycle lookup 0x100 -> taken, 0x80. Lookup 0x100+4*ENTRIES (tag alias) -> pred_taken=0, target=0x100+4*ENTRIES+4.
- CNT_W=2, GSHARE_EN undefined:
  - Allocate 0x100 taken (ctr=2).
  - Three not-taken updates -> ctr 1, 0, 0 (saturated); predicts not-taken.
  - One taken -> ctr=1, still not-taken. Second taken -> ctr=2, predicts taken.
- JAL update pc=0x200 target=0x40 -> lookup 0x200 taken, 0x40. Subsequent conditional-style ctr changes are not applied while is_jal=1.
- Same cycle: update 0x300 taken + lookup 0x300 -> pred_taken=0 that cycle, 1 next cycle. Then clear+upd_valid together -> lookup 0x300 misses next cycle.
- mispredict: upd_valid=1, taken=1, target=0x90, pred_taken=1, pred_target=0x80 -> mispredict=1. Same with target=0x80 -> 0. taken=0, pred_taken=0 -> 0.
